// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state types for the burst memory slave.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI4 next-beat address and burst legality check.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  burst_ok
);

    localparam int LOG2_BYTES = $clog2(DATA_WIDTH / 8);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    // NOTE: every output gets a value before the case, so no path leaves one unassigned and no latch appears.
    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = addr + step;
            BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:    next_addr = addr;
        endcase
        burst_ok = (size == 3'(LOG2_BYTES)) && (burst != 2'b11) &&
                   !((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave: independent write and read FSMs over a byte-strobed word memory.
module axi_burst_mem_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 128
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int LOG2_BYTES = $clog2(STRB_W);
    localparam int IDX_W      = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    wr_state_t             wr_state;
    logic [ID_WIDTH-1:0]   wr_id;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_next, wr_word;
    logic [7:0]            wr_len, wr_cnt;
    logic [2:0]            wr_size;
    logic [1:0]            wr_burst;
    logic                  wr_err, wr_ok, wr_fire, wr_beat_err;
    logic [STRB_W-1:0]     mem_we;

    rd_state_t             rd_state;
    logic [ADDR_WIDTH-1:0] rd_addr, rd_next, rd_word, rd_cur_addr;
    logic [7:0]            rd_len, rd_cnt, rd_cur_len;
    logic [2:0]            rd_size, rd_cur_size;
    logic [1:0]            rd_burst, rd_cur_burst;
    logic                  rd_ok, rd_beat_err;
    logic [DATA_WIDTH-1:0] rd_beat_data;
    logic [1:0]            rd_beat_resp;

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr_gen (
        .addr(wr_addr), .len(wr_len), .size(wr_size), .burst(wr_burst),
        .next_addr(wr_next), .burst_ok(wr_ok)
    );

    // Read side looks at the AR inputs while idle so the first beat is fetched on the handshake itself.
    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rd_gen (
        .addr(rd_cur_addr), .len(rd_cur_len), .size(rd_cur_size), .burst(rd_cur_burst),
        .next_addr(rd_next), .burst_ok(rd_ok)
    );

    always_comb begin
        wr_word     = wr_addr >> LOG2_BYTES;
        wr_fire     = resetn && (wr_state == W_DATA) && wvalid && wready;
        wr_beat_err = !wr_ok || (wr_word >= ADDR_WIDTH'(MEM_DEPTH)) || (wlast != (wr_cnt == wr_len));
        mem_we      = (wr_fire && !wr_beat_err) ? wstrb : '0;
    end

    always_comb begin
        rd_cur_addr  = (rd_state == R_IDLE) ? araddr  : rd_addr;
        rd_cur_len   = (rd_state == R_IDLE) ? arlen   : rd_len;
        rd_cur_size  = (rd_state == R_IDLE) ? arsize  : rd_size;
        rd_cur_burst = (rd_state == R_IDLE) ? arburst : rd_burst;
        rd_word      = rd_cur_addr >> LOG2_BYTES;
        rd_beat_err  = !rd_ok || (rd_word >= ADDR_WIDTH'(MEM_DEPTH));
        rd_beat_data = rd_beat_err ? '0 : mem[rd_word[IDX_W-1:0]];
        rd_beat_resp = rd_beat_err ? RESP_SLVERR : RESP_OKAY;
    end

    // NOTE: the memory array has no reset; its contents survive resetn.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (mem_we[b]) mem[wr_word[IDX_W-1:0]][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // NOTE: state and outputs use <= so every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_state <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bid      <= '0;
            bresp    <= RESP_OKAY;
            wr_id    <= '0;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_size  <= '0;
            wr_burst <= '0;
            wr_cnt   <= '0;
            wr_err   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        wr_id    <= awid;
                        wr_addr  <= awaddr;
                        wr_len   <= awlen;
                        wr_size  <= awsize;
                        wr_burst <= awburst;
                        wr_cnt   <= '0;
                        wr_err   <= 1'b0;
                        wr_state <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wvalid && wready) begin
                        wr_addr <= wr_next;
                        wr_cnt  <= wr_cnt + 8'd1;
                        wr_err  <= wr_err | wr_beat_err;
                        // Beat count, not wlast, ends the burst; a wlast mismatch only flags an error.
                        if (wr_cnt == wr_len) begin
                            wready   <= 1'b0;
                            bvalid   <= 1'b1;
                            bid      <= wr_id;
                            bresp    <= (wr_err || wr_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            wr_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_state <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
            rd_cnt   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        arready  <= 1'b0;
                        rid      <= arid;
                        rd_len   <= arlen;
                        rd_size  <= arsize;
                        rd_burst <= arburst;
                        rd_addr  <= rd_next;
                        rd_cnt   <= '0;
                        rvalid   <= 1'b1;
                        rlast    <= (arlen == 8'd0);
                        rdata    <= rd_beat_data;
                        rresp    <= rd_beat_resp;
                        rd_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid   <= 1'b0;
                            rlast    <= 1'b0;
                            arready  <= 1'b1;
                            rd_state <= R_IDLE;
                        end else begin
                            rd_cnt  <= rd_cnt + 8'd1;
                            rlast   <= (rd_cnt + 8'd1 == rd_len);
                            rdata   <= rd_beat_data;
                            rresp   <= rd_beat_resp;
                            rd_addr <= rd_next;
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Self-checking bench: directed and random AXI4 bursts against a word-array reference model.
module tb_axi_burst_mem_slave;
    import axi_pkg::*;

    localparam int AW = 32, DW = 32, IW = 4, DEPTH = 128;

    logic          clk, resetn;
    logic [IW-1:0] awid, bid, arid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;

    axi_burst_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0, n_pass = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] wbuf_data [256];
    logic [3:0]  wbuf_strb [256];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Byte address of beat i, straight from the AXI burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                              input logic [1:0] burst, input int i);
        logic [31:0] step, bnd, base;
        step = 32'(1) << size;
        case (burst)
            BURST_FIXED: return a;
            BURST_WRAP: begin
                bnd  = 32'(len + 1) * step;
                base = a - (a % bnd);
                return base + ((a - base + 32'(i) * step) % bnd);
            end
            default: return a + 32'(i) * step;
        endcase
    endfunction

    function automatic bit burst_bad(input int len, input int size, input logic [1:0] burst);
        return size != 2 || burst == 2'b11 || (burst == BURST_WRAP && !(len inside {1, 3, 7, 15}));
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "/ctrl_zero"}, {awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rresp}, 0);
        check({name, "/rdata_zero"}, rdata, 0);
    endtask

    task automatic send_aw(input string name, input logic [3:0] id, input logic [31:0] addr,
                           input int len, input int size, input logic [1:0] burst);
        int c = 0;
        awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = burst; awvalid = 1'b1;
        while (!awready && c < 100) begin step_clk(); c++; end
        if (!awready) check({name, "/aw_timeout"}, awready, 1);
        step_clk();
        awvalid = 1'b0;
    endtask

    task automatic send_w_beat(input string name, input logic [31:0] data, input logic [3:0] strb, input logic last);
        int c = 0;
        repeat ($urandom_range(0, 2)) step_clk();
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (!wready && c < 100) begin step_clk(); c++; end
        if (!wready) check({name, "/w_timeout"}, wready, 1);
        step_clk();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic recv_b(input string name, input logic [3:0] exp_id, input logic [1:0] exp_resp);
        int c = 0;
        while (!bvalid && c < 100) begin step_clk(); c++; end
        if (!bvalid) check({name, "/b_timeout"}, bvalid, 1);
        repeat ($urandom_range(0, 2)) begin step_clk(); check({name, "/b_held"}, bvalid, 1); end
        bready = 1'b1;
        check({name, "/bid"}, bid, exp_id);
        check({name, "/bresp"}, bresp, exp_resp);
        step_clk();
        bready = 1'b0;
        check({name, "/b_cleared"}, bvalid, 0);
    endtask

    // Drives wbuf_data/wbuf_strb as the burst; bad_beat gets an inverted wlast.
    task automatic do_write(input string name, input logic [3:0] id, input logic [31:0] addr,
                            input int len, input int size, input logic [1:0] burst, input int bad_beat);
        logic        any_err = 1'b0, err, last;
        logic [31:0] a, w;
        send_aw(name, id, addr, len, size, burst);
        for (int i = 0; i <= len; i++) begin
            a    = beat_addr(addr, len, size, burst, i);
            w    = a >> 2;
            last = (i == len) ^ (i == bad_beat);
            err  = burst_bad(len, size, burst) || (w >= DEPTH) || (i == bad_beat);
            send_w_beat(name, wbuf_data[i], wbuf_strb[i], last);
            if (!err)
                for (int b = 0; b < 4; b++)
                    if (wbuf_strb[i][b]) model_mem[w[6:0]][8*b +: 8] = wbuf_data[i][8*b +: 8];
            any_err |= err;
        end
        recv_b(name, id, any_err ? RESP_SLVERR : RESP_OKAY);
    endtask

    task automatic send_ar(input string name, input logic [3:0] id, input logic [31:0] addr,
                           input int len, input int size, input logic [1:0] burst);
        int c = 0;
        arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = burst; arvalid = 1'b1;
        while (!arready && c < 100) begin step_clk(); c++; end
        if (!arready) check({name, "/ar_timeout"}, arready, 1);
        step_clk();
        arvalid = 1'b0;
        check({name, "/rvalid_latency"}, rvalid, 1);
    endtask

    // mode 0: rready held high, 1: toggles every cycle, 2: random.
    task automatic do_read(input string name, input logic [3:0] id, input logic [31:0] addr,
                           input int len, input int size, input logic [1:0] burst, input int mode);
        logic [31:0] exp_d [256];
        logic [1:0]  exp_r [256];
        logic [31:0] a, w;
        logic        err;
        int          k = 0, cyc = 0;
        for (int i = 0; i <= len; i++) begin
            a        = beat_addr(addr, len, size, burst, i);
            w        = a >> 2;
            err      = burst_bad(len, size, burst) || (w >= DEPTH);
            exp_d[i] = err ? 32'h0 : model_mem[w[6:0]];
            exp_r[i] = err ? RESP_SLVERR : RESP_OKAY;
        end
        send_ar(name, id, addr, len, size, burst);
        while (k <= len && cyc < 4000) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 2 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (rvalid) begin
                check({name, "/rdata"}, rdata, exp_d[k]);
                if (rready) begin
                    check({name, "/rresp"}, rresp, exp_r[k]);
                    check({name, "/rlast"}, rlast, (k == len));
                    check({name, "/rid"}, rid, id);
                    k++;
                end
            end
            step_clk();
            cyc++;
        end
        rready = 1'b0;
        if (k <= len) check({name, "/r_timeout"}, k, len + 1);
        check({name, "/r_idle_after_last"}, rvalid, 0);
    endtask

    task automatic fill_wbuf(input int len, input logic [3:0] strb_mode, input bit rand_strb);
        for (int i = 0; i <= len; i++) begin
            wbuf_data[i] = $urandom;
            wbuf_strb[i] = rand_strb ? 4'($urandom) : strb_mode;
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: bench stalled, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) step_clk();
        check_reset_outputs("reset");
        resetn = 1'b1;
        step_clk();

        fill_wbuf(DEPTH - 1, 4'hF, 0);
        do_write("fill", 4'h1, 32'h0, DEPTH - 1, 2, BURST_INCR, -1);

        for (int i = 0; i < 8; i++) begin wbuf_data[i] = 32'd10 + 32'(i); wbuf_strb[i] = 4'hF; end
        do_write("incr_w", 4'hA, 32'h0, 7, 2, BURST_INCR, -1);
        do_read("incr_r", 4'h5, 32'h0, 7, 2, BURST_INCR, 0);

        for (int i = 0; i < 4; i++) begin wbuf_data[i] = 32'h200 + 32'(i); wbuf_strb[i] = 4'hF; end
        do_write("wrap_w", 4'h2, 32'h8, 3, 2, BURST_WRAP, -1);
        do_read("wrap_r", 4'h2, 32'h0, 3, 2, BURST_INCR, 0);

        wbuf_data[0] = 32'h1122_3344; wbuf_strb[0] = 4'hF;
        do_write("strb_base", 4'h3, 32'h14, 0, 2, BURST_INCR, -1);
        wbuf_data[0] = 32'hAABB_CCDD; wbuf_strb[0] = 4'b0101;
        do_write("strb_part", 4'h3, 32'h14, 0, 2, BURST_INCR, -1);
        do_read("strb_r", 4'h3, 32'h14, 0, 2, BURST_INCR, 0);

        do_read("oob_r", 4'h4, 32'((DEPTH - 2) * 4), 3, 2, BURST_INCR, 0);
        fill_wbuf(3, 4'hF, 0);
        do_write("oob_w", 4'h4, 32'((DEPTH - 2) * 4), 3, 2, BURST_INCR, -1);
        do_read("oob_w_r", 4'h4, 32'((DEPTH - 2) * 4), 1, 2, BURST_INCR, 2);

        do_read("toggle_r", 4'h6, 32'h0, 7, 2, BURST_INCR, 1);
        fill_wbuf(7, 4'h0, 0);
        do_write("early_wlast", 4'h7, 32'h20, 7, 2, BURST_INCR, 2);

        fill_wbuf(1, 4'hF, 0);
        do_write("bad_size_w", 4'h8, 32'h28, 1, 1, BURST_INCR, -1);
        do_read("bad_size_chk", 4'h8, 32'h28, 1, 2, BURST_INCR, 0);
        do_read("bad_burst_r", 4'h9, 32'h30, 3, 2, 2'b11, 0);
        fill_wbuf(2, 4'hF, 0);
        do_write("bad_wrap_w", 4'h9, 32'h40, 2, 2, BURST_WRAP, -1);
        fill_wbuf(3, 4'h0, 1);
        do_write("fixed_w", 4'hB, 32'h50, 3, 2, BURST_FIXED, -1);
        do_read("fixed_r", 4'hB, 32'h50, 3, 2, BURST_FIXED, 2);
        fill_wbuf(3, 4'hF, 0);
        do_write("hiwrap_w", 4'hC, 32'hFFFF_FFF8, 3, 2, BURST_INCR, -1);
        do_read("hiwrap_r", 4'hC, 32'hFFFF_FFF8, 3, 2, BURST_INCR, 0);

        fill_wbuf(7, 4'hF, 0);
        fork
            do_write("par_w", 4'hD, 32'h100, 7, 2, BURST_INCR, -1);
            do_read("par_r", 4'hE, 32'h0, 7, 2, BURST_INCR, 2);
        join

        fill_wbuf(7, 4'hF, 0);
        send_aw("rst_mid", 4'h3, 32'h40, 7, 2, BURST_INCR);
        for (int i = 0; i < 4; i++) begin
            send_w_beat("rst_mid", wbuf_data[i], 4'hF, 1'b0);
            model_mem[16 + i] = wbuf_data[i];
        end
        send_ar("rst_mid", 4'h6, 32'h100, 7, 2, BURST_INCR);
        rready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("rst_mid/rdata", rdata, model_mem[64 + i]);
            step_clk();
        end
        rready = 1'b0;
        resetn = 1'b0;
        step_clk();
        check_reset_outputs("rst_mid");
        resetn = 1'b1;
        step_clk();
        fill_wbuf(3, 4'hF, 0);
        do_write("post_rst_w", 4'h1, 32'h180, 3, 2, BURST_INCR, -1);
        do_read("post_rst_r", 4'h2, 32'h40, 7, 2, BURST_INCR, 0);

        for (int n = 0; n < 25; n++) begin
            int          sel, len, size, bad;
            logic [1:0]  burst;
            logic [31:0] addr;
            sel   = $urandom_range(0, 9);
            burst = (sel < 2) ? BURST_FIXED : (sel < 6) ? BURST_INCR : (sel < 9) ? BURST_WRAP : 2'b11;
            if (burst == BURST_WRAP) begin
                case ($urandom_range(0, 4))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    3: len = 15;
                    default: len = 5;
                endcase
            end else begin
                len = $urandom_range(0, 15);
            end
            size = ($urandom_range(0, 9) == 0) ? 1 : 2;
            addr = 32'($urandom_range(0, DEPTH + 4)) * 32'd4;
            bad  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
            fill_wbuf(len, 4'h0, bad < 0);
            do_write("rand_w", 4'($urandom), addr, len, size, burst, bad);
            do_read("rand_r", 4'($urandom), addr, len, size, burst, $urandom_range(0, 2));
        end

        do_read("final_r", 4'hF, 32'h0, DEPTH - 1, 2, BURST_INCR, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
